memory_requester: RTL and testbench
===================================

MEMORY_REQUESTER -- requirements
Module: memory_requester

Interface
REQ-001 SHALL have parameter MEMORY_DEPTH, default 64, meaning words per region (ROM and RAM).
REQ-002 SHALL have parameter DATA_WIDTH, default 32, meaning data and address width.
REQ-003 SHALL have parameter ROM_BASE, default 32'h0040_0000, meaning instruction-region byte base.
REQ-004 SHALL have parameter RAM_BASE, default 32'h1001_0000, meaning data-region byte base.
REQ-005 Ports: clk  in  1  single clock, all state on rising edge; reset  in  1  asynchronous, active-low.
REQ-006 Ports: Req_Valid_i  in  1  request offered; Req_Ready_o  out  1  request accepted this cycle.
REQ-007 Ports: Req_Write_i  in  1  1=write, 0=read; Req_Len_i  in  3  burst length minus one (reads only).
REQ-008 Ports: Req_Addr_i  in  DATA_WIDTH  byte address; Req_Wdata_i  in  DATA_WIDTH  write data.
REQ-009 Ports: Rsp_Valid_o  out  1; Rsp_Ready_i  in  1; Rsp_Rdata_o  out  DATA_WIDTH; Rsp_Err_o  out  1; Rsp_Last_o  out  1.
REQ-010 Ports: Address_o  out  DATA_WIDTH; Write_Data_o  out  DATA_WIDTH; Write_Enable_o  out  1; Read_Data_i  in  DATA_WIDTH (memory-system side).

Function
REQ-011 SHALL be the initiator for a memory system with synchronous ROM/RAM: data for an address sampled at edge k is on Read_Data_i during the cycle after edge k, captured at edge k+1.
REQ-012 States SHALL be IDLE, WRITE, ISSUE, WAIT, RESP.
REQ-013 Req_Ready_o SHALL be 1 only in IDLE; a transfer occurs when Req_Valid_i and Req_Ready_o are both 1.
REQ-014 On acceptance SHALL latch address, write flag, wdata, and length (length forced to 0 for writes).
REQ-015 Request error SHALL be flagged if Req_Addr_i[1:0]!=0, if the burst [addr, addr+4*len] is not wholly inside [base, base+4*MEMORY_DEPTH) of one region, or if a write targets ROM.
REQ-016 Errored request: IDLE->RESP directly, no memory access, Write_Enable_o stays 0, single response with Rsp_Err_o=1, Rsp_Last_o=1, Rsp_Rdata_o=0.
REQ-017 Valid write: IDLE->WRITE; Write_Enable_o=1 for exactly one cycle with Address_o and Write_Data_o = latched values; then RESP with Rsp_Err_o=0, Rsp_Rdata_o=0, Rsp_Last_o=1.
REQ-018 Valid read: IDLE->ISSUE (drive Address_o) ->WAIT (capture Read_Data_i into Rsp_Rdata_o at end of WAIT) ->RESP.
REQ-019 Read latency: Req accept edge to Rsp_Valid_o high SHALL be 3 cycles; write latency 2 cycles.
REQ-020 In RESP, Rsp_Valid_o=1 and Rsp_Rdata_o/Rsp_Err_o/Rsp_Last_o SHALL hold stable until Rsp_Ready_i=1.
REQ-021 On RESP handshake: if words remain, address+=4, remaining-=1, ->ISSUE; else ->IDLE.
REQ-022 Rsp_Last_o SHALL be 1 only on the final word of a burst (remaining count 0).
REQ-023 Burst of N words SHALL produce exactly N responses at consecutive addresses; minimum 3-cycle spacing with Rsp_Ready_i held 1.
REQ-024 Address_o SHALL hold its last value in IDLE/RESP (no glitch to other addresses); Write_Data_o SHALL hold latched wdata.
REQ-025 Write_Enable_o SHALL be 1 only in WRITE.
REQ-026 Address arithmetic SHALL be DATA_WIDTH-bit unsigned; wrap cannot occur since REQ-015 bounds the burst.

Reset
REQ-027 While reset=0: state IDLE, Req_Ready_o=0, Rsp_Valid_o=0, Rsp_Rdata_o=0, Rsp_Err_o=0, Rsp_Last_o=0, Address_o=0, Write_Data_o=0, Write_Enable_o=0, counters 0.
REQ-028 Req_Ready_o SHALL rise the first cycle after reset deassertion.
REQ-029 Reset asserted mid-burst or mid-write SHALL abort immediately; no further responses or Write_Enable_o pulses from the aborted request.

Verification
REQ-030 Read ROM 0x0040_0004, len 0, ROM word1=0x2008_0005 -> one response 3 cycles later, Rdata=0x2008_0005, Err=0, Last=1.
REQ-031 Write 0xDEAD_BEEF to 0x1001_0008, then read it -> one Write_Enable_o pulse with Address_o=0x1001_0008; read returns 0xDEAD_BEEF.
REQ-032 Read burst len=3 from 0x1001_0000 with Rsp_Ready_i low 2 cycles on word 2 -> 4 responses, addresses +0,+4,+8,+C, data held during stall, Last only on 4th.
REQ-033 Write to 0x0040_0000; read 0x1001_0002; read len=1 at 0x1001_00FC -> each a single Err=1 response, Write_Enable_o never 1.
REQ-034 Assert reset during WAIT of word 2 in a 4-word burst -> all outputs 0 at once; after release Req_Ready_o=1 and no stray response.

Source files
------------

// File: rtl/memory_requester.sv
// Initiator front end for a synchronous ROM/RAM memory port: accepts single reads,
// read bursts and single writes, and returns one response per word.
module memory_requester #(
    parameter int                    MEMORY_DEPTH = 64,
    parameter int                    DATA_WIDTH   = 32,
    parameter logic [DATA_WIDTH-1:0] ROM_BASE     = 32'h0040_0000,
    parameter logic [DATA_WIDTH-1:0] RAM_BASE     = 32'h1001_0000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  Req_Valid_i,
    output logic                  Req_Ready_o,
    input  logic                  Req_Write_i,
    input  logic [2:0]            Req_Len_i,
    input  logic [DATA_WIDTH-1:0] Req_Addr_i,
    input  logic [DATA_WIDTH-1:0] Req_Wdata_i,
    output logic                  Rsp_Valid_o,
    input  logic                  Rsp_Ready_i,
    output logic [DATA_WIDTH-1:0] Rsp_Rdata_o,
    output logic                  Rsp_Err_o,
    output logic                  Rsp_Last_o,
    output logic [DATA_WIDTH-1:0] Address_o,
    output logic [DATA_WIDTH-1:0] Write_Data_o,
    output logic                  Write_Enable_o,
    input  logic [DATA_WIDTH-1:0] Read_Data_i
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WRITE = 3'd1,
        ISSUE = 3'd2,
        WAIT  = 3'd3,
        RESP  = 3'd4
    } state_t;

    // One extra bit so that base + region size and burst end never wrap.
    localparam int            AW           = DATA_WIDTH + 1;
    localparam logic [AW-1:0] REGION_BYTES = AW'(4 * MEMORY_DEPTH);
    localparam logic [AW-1:0] ROM_LO       = {1'b0, ROM_BASE};
    localparam logic [AW-1:0] ROM_HI       = ROM_LO + REGION_BYTES;
    localparam logic [AW-1:0] RAM_LO       = {1'b0, RAM_BASE};
    localparam logic [AW-1:0] RAM_HI       = RAM_LO + REGION_BYTES;

    state_t                  state_reg;
    state_t                  state_next;
    logic                    ready_en_reg;
    logic [2:0]              remaining_reg;
    logic [DATA_WIDTH-1:0]   addr_reg;
    logic [DATA_WIDTH-1:0]   wdata_reg;
    logic [DATA_WIDTH-1:0]   rsp_rdata_reg;
    logic                    rsp_err_reg;
    logic                    rsp_last_reg;

    logic                    req_fire;
    logic [2:0]              eff_len;
    logic [AW-1:0]           burst_first;
    logic [AW-1:0]           burst_last;
    logic                    in_rom;
    logic                    in_ram;
    logic                    req_err;

    assign req_fire = Req_Valid_i && Req_Ready_o;

    // Request legality: aligned, whole burst inside one region, no writes to ROM.
    always_comb begin
        eff_len     = Req_Write_i ? 3'd0 : Req_Len_i;
        burst_first = {1'b0, Req_Addr_i};
        burst_last  = burst_first + {{(AW-5){1'b0}}, eff_len, 2'b00};
        in_rom      = (burst_first >= ROM_LO) && (burst_last < ROM_HI);
        in_ram      = (burst_first >= RAM_LO) && (burst_last < RAM_HI);
        req_err     = (Req_Addr_i[1:0] != 2'b00) || !(in_rom || in_ram) || (Req_Write_i && in_rom);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (req_fire) begin
                    if (req_err) begin
                        state_next = RESP;
                    end else if (Req_Write_i) begin
                        state_next = WRITE;
                    end else begin
                        state_next = ISSUE;
                    end
                end
            end
            WRITE:   state_next = RESP;
            ISSUE:   state_next = WAIT;
            WAIT:    state_next = RESP;
            RESP: begin
                if (Rsp_Ready_i) begin
                    state_next = (remaining_reg != 3'd0) ? ISSUE : IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        Req_Ready_o    = 1'b0;
        Rsp_Valid_o    = 1'b0;
        Rsp_Err_o      = 1'b0;
        Rsp_Last_o     = 1'b0;
        Write_Enable_o = 1'b0;
        case (state_reg)
            IDLE:  Req_Ready_o = ready_en_reg;
            WRITE: Write_Enable_o = 1'b1;
            RESP: begin
                Rsp_Valid_o = 1'b1;
                Rsp_Err_o   = rsp_err_reg;
                Rsp_Last_o  = rsp_last_reg;
            end
            default: ;
        endcase
    end

    // Datapath: the memory port address only moves for legal requests and burst steps.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ready_en_reg  <= 1'b0;
            remaining_reg <= 3'd0;
            addr_reg      <= '0;
            wdata_reg     <= '0;
            rsp_rdata_reg <= '0;
            rsp_err_reg   <= 1'b0;
            rsp_last_reg  <= 1'b0;
        end else begin
            ready_en_reg <= 1'b1;
            case (state_reg)
                IDLE: begin
                    if (req_fire) begin
                        wdata_reg     <= Req_Wdata_i;
                        remaining_reg <= req_err ? 3'd0 : eff_len;
                        if (req_err) begin
                            rsp_rdata_reg <= '0;
                            rsp_err_reg   <= 1'b1;
                            rsp_last_reg  <= 1'b1;
                        end else begin
                            addr_reg <= Req_Addr_i;
                        end
                    end
                end
                WRITE: begin
                    rsp_rdata_reg <= '0;
                    rsp_err_reg   <= 1'b0;
                    rsp_last_reg  <= 1'b1;
                end
                WAIT: begin
                    rsp_rdata_reg <= Read_Data_i;
                    rsp_err_reg   <= 1'b0;
                    rsp_last_reg  <= (remaining_reg == 3'd0);
                end
                RESP: begin
                    if (Rsp_Ready_i && (remaining_reg != 3'd0)) begin
                        addr_reg      <= addr_reg + DATA_WIDTH'(4);
                        remaining_reg <= remaining_reg - 3'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign Rsp_Rdata_o  = rsp_rdata_reg;
    assign Address_o    = addr_reg;
    assign Write_Data_o = wdata_reg;

endmodule

// File: tb/tb_memory_requester.sv
// Bench for memory_requester: synchronous ROM/RAM model on the memory port and a
// response scoreboard fed by the request-side scenarios.
module tb_memory_requester;

    localparam int          DW       = 32;
    localparam int          DEPTH    = 64;
    localparam logic [31:0] ROM_BASE = 32'h0040_0000;
    localparam logic [31:0] RAM_BASE = 32'h1001_0000;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          Req_Valid_i = 1'b0;
    logic          Req_Ready_o;
    logic          Req_Write_i = 1'b0;
    logic [2:0]    Req_Len_i = 3'd0;
    logic [DW-1:0] Req_Addr_i = '0;
    logic [DW-1:0] Req_Wdata_i = '0;
    logic          Rsp_Valid_o;
    logic          Rsp_Ready_i = 1'b1;
    logic [DW-1:0] Rsp_Rdata_o;
    logic          Rsp_Err_o;
    logic          Rsp_Last_o;
    logic [DW-1:0] Address_o;
    logic [DW-1:0] Write_Data_o;
    logic          Write_Enable_o;
    logic [DW-1:0] Read_Data_i;

    memory_requester #(
        .MEMORY_DEPTH (DEPTH),
        .DATA_WIDTH   (DW),
        .ROM_BASE     (ROM_BASE),
        .RAM_BASE     (RAM_BASE)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .Req_Valid_i    (Req_Valid_i),
        .Req_Ready_o    (Req_Ready_o),
        .Req_Write_i    (Req_Write_i),
        .Req_Len_i      (Req_Len_i),
        .Req_Addr_i     (Req_Addr_i),
        .Req_Wdata_i    (Req_Wdata_i),
        .Rsp_Valid_o    (Rsp_Valid_o),
        .Rsp_Ready_i    (Rsp_Ready_i),
        .Rsp_Rdata_o    (Rsp_Rdata_o),
        .Rsp_Err_o      (Rsp_Err_o),
        .Rsp_Last_o     (Rsp_Last_o),
        .Address_o      (Address_o),
        .Write_Data_o   (Write_Data_o),
        .Write_Enable_o (Write_Enable_o),
        .Read_Data_i    (Read_Data_i)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory system model
    logic [31:0] ram [DEPTH];
    logic [31:0] shadow [DEPTH];

    function automatic logic [31:0] rom_word(input int i);
        return 32'h2008_0001 | 32'(i * 4);
    endfunction

    function automatic logic [31:0] ram_init(input int i);
        return 32'hA500_0000 + 32'(i);
    endfunction

    function automatic logic [31:0] mem_read(input logic [31:0] a);
        if (a >= ROM_BASE && a < ROM_BASE + 32'(4 * DEPTH)) return rom_word(int'((a - ROM_BASE) >> 2));
        if (a >= RAM_BASE && a < RAM_BASE + 32'(4 * DEPTH)) return ram[6'((a - RAM_BASE) >> 2)];
        return 32'h0;
    endfunction

    always @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) ram[i] <= ram_init(i);
            Read_Data_i <= '0;
        end else begin
            if (Write_Enable_o && Address_o >= RAM_BASE && Address_o < RAM_BASE + 32'(4 * DEPTH))
                ram[6'((Address_o - RAM_BASE) >> 2)] <= Write_Data_o;
            Read_Data_i <= mem_read(Address_o);
        end
    end

    // Scoreboard queues
    typedef struct {
        logic [31:0] data;
        logic        err;
        logic        last;
        int          hs;
    } rsp_t;

    rsp_t obs_q[$];
    rsp_t exp_q[$];
    int          we_pulses = 0;
    logic [31:0] we_addr = '0;
    logic [31:0] we_data = '0;

    always @(negedge clk) begin
        rsp_t r;
        if (Rsp_Valid_o && Rsp_Ready_i) begin
            r.data = Rsp_Rdata_o;
            r.err  = Rsp_Err_o;
            r.last = Rsp_Last_o;
            r.hs   = cyc + 1;
            obs_q.push_back(r);
        end
        if (Write_Enable_o) begin
            we_pulses = we_pulses + 1;
            we_addr   = Address_o;
            we_data   = Write_Data_o;
        end
    end

    function automatic void expect_rsp(input logic [31:0] d, input logic e, input logic l);
        rsp_t r;
        r.data = d;
        r.err  = e;
        r.last = l;
        r.hs   = 0;
        exp_q.push_back(r);
    endfunction

    task automatic send(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [2:0] len, output int acc);
        int t = 0;
        @(negedge clk);
        while (!Req_Ready_o && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (!Req_Ready_o) begin
            checks++;
            errors++;
            $display("FAIL req_ready_timeout got ready=%b required 1", Req_Ready_o);
        end
        Req_Valid_i = 1'b1;
        Req_Write_i = wr;
        Req_Addr_i  = addr;
        Req_Wdata_i = wd;
        Req_Len_i   = len;
        @(posedge clk);
        #1;
        acc = cyc;
        Req_Valid_i = 1'b0;
        $display("req wr=%b addr=%h wdata=%h len=%0d accepted at cycle %0d", wr, addr, wd, len, acc);
    endtask

    task automatic wait_obs(input int n, output bit ok);
        int t = 0;
        while (obs_q.size() < n && t < 200) begin
            @(negedge clk);
            t++;
        end
        ok = (obs_q.size() >= n);
    endtask

    task automatic wait_valid(output bit ok);
        int t = 0;
        @(negedge clk);
        while (!Rsp_Valid_o && t < 50) begin
            @(negedge clk);
            t++;
        end
        ok = Rsp_Valid_o;
    endtask

    task automatic test_reset();
        logic [3*DW+4:0] outs;
        repeat (3) @(posedge clk);
        @(negedge clk);
        outs = {Req_Ready_o, Rsp_Valid_o, Rsp_Err_o, Rsp_Last_o, Write_Enable_o,
                Rsp_Rdata_o, Address_o, Write_Data_o};
        checks++;
        if (outs !== '0) begin
            errors++;
            $display("FAIL reset_outputs got %h required 0", outs);
        end
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (Req_Ready_o !== 1'b1) begin
            errors++;
            $display("FAIL ready_after_reset got %b required 1", Req_Ready_o);
        end
        $display("reset released, ready=%b", Req_Ready_o);
    endtask

    task automatic test_rom_read();
        int acc;
        bit ok;
        rsp_t o;
        rsp_t e;
        send(1'b0, 32'h0040_0004, 32'h0, 3'd0, acc);
        expect_rsp(32'h2008_0005, 1'b0, 1'b1);
        wait_obs(1, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL rom_read_timeout got %0d responses required 1", obs_q.size());
        end else begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            if (o.data !== e.data || o.err !== e.err || o.last !== e.last) begin
                errors++;
                $display("FAIL rom_read got data=%h err=%b last=%b required data=%h err=%b last=%b",
                         o.data, o.err, o.last, e.data, e.err, e.last);
            end
            checks++;
            if (o.hs - acc != 3) begin
                errors++;
                $display("FAIL rom_read_latency got %0d required 3", o.hs - acc);
            end
            $display("rsp rom_read data=%h err=%b last=%b latency=%0d", o.data, o.err, o.last, o.hs - acc);
        end
    endtask

    task automatic test_write_read();
        int acc;
        int we0;
        bit ok;
        rsp_t o;
        rsp_t e;
        we0 = we_pulses;
        send(1'b1, 32'h1001_0008, 32'hDEAD_BEEF, 3'd5, acc);
        shadow[2] = 32'hDEAD_BEEF;
        expect_rsp(32'h0, 1'b0, 1'b1);
        wait_obs(1, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL write_timeout got %0d responses required 1", obs_q.size());
        end else begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            if (o.data !== e.data || o.err !== e.err || o.last !== e.last) begin
                errors++;
                $display("FAIL write_rsp got data=%h err=%b last=%b required data=%h err=%b last=%b",
                         o.data, o.err, o.last, e.data, e.err, e.last);
            end
            checks++;
            if (o.hs - acc != 2) begin
                errors++;
                $display("FAIL write_latency got %0d required 2", o.hs - acc);
            end
            $display("rsp write err=%b last=%b latency=%0d", o.err, o.last, o.hs - acc);
        end
        checks++;
        if (we_pulses - we0 != 1 || we_addr !== 32'h1001_0008 || we_data !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL write_pulse got pulses=%0d addr=%h data=%h required pulses=1 addr=10010008 data=deadbeef",
                     we_pulses - we0, we_addr, we_data);
        end

        send(1'b0, 32'h1001_0008, 32'h0, 3'd0, acc);
        expect_rsp(32'hDEAD_BEEF, 1'b0, 1'b1);
        wait_obs(1, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL readback_timeout got %0d responses required 1", obs_q.size());
        end else begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            if (o.data !== e.data || o.err !== e.err || o.last !== e.last || o.hs - acc != 3) begin
                errors++;
                $display("FAIL readback got data=%h err=%b last=%b lat=%0d required data=%h err=%b last=%b lat=3",
                         o.data, o.err, o.last, o.hs - acc, e.data, e.err, e.last);
            end
            $display("rsp readback data=%h err=%b last=%b", o.data, o.err, o.last);
        end
    endtask

    task automatic test_burst_stall();
        int acc;
        bit ok;
        rsp_t o;
        rsp_t e;
        int hs[4];
        logic [31:0] held;
        send(1'b0, RAM_BASE, 32'h0, 3'd3, acc);
        for (int i = 0; i < 4; i++) expect_rsp(shadow[i], 1'b0, i == 3);
        wait_valid(ok);
        @(posedge clk);
        #1;
        Rsp_Ready_i = 1'b0;
        wait_valid(ok);
        held = Rsp_Rdata_o;
        checks++;
        if (!ok || held !== shadow[1] || Rsp_Last_o !== 1'b0) begin
            errors++;
            $display("FAIL stall_first got valid=%b data=%h last=%b required valid=1 data=%h last=0",
                     Rsp_Valid_o, held, Rsp_Last_o, shadow[1]);
        end
        @(negedge clk);
        checks++;
        if (Rsp_Valid_o !== 1'b1 || Rsp_Rdata_o !== held || Rsp_Last_o !== 1'b0 || Rsp_Err_o !== 1'b0) begin
            errors++;
            $display("FAIL stall_hold got valid=%b data=%h last=%b required valid=1 data=%h last=0",
                     Rsp_Valid_o, Rsp_Rdata_o, Rsp_Last_o, held);
        end
        @(posedge clk);
        #1;
        Rsp_Ready_i = 1'b1;
        wait_obs(4, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL burst_timeout got %0d responses required 4", obs_q.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                o = obs_q.pop_front();
                e = exp_q.pop_front();
                hs[i] = o.hs;
                checks++;
                if (o.data !== e.data || o.err !== e.err || o.last !== e.last) begin
                    errors++;
                    $display("FAIL burst_word%0d got data=%h err=%b last=%b required data=%h err=%b last=%b",
                             i, o.data, o.err, o.last, e.data, e.err, e.last);
                end
                $display("rsp burst word%0d data=%h last=%b at cycle %0d", i, o.data, o.last, o.hs);
            end
            checks++;
            if (hs[0] - acc != 3 || hs[1] - hs[0] != 5 || hs[2] - hs[1] != 3 || hs[3] - hs[2] != 3) begin
                errors++;
                $display("FAIL burst_spacing got %0d,%0d,%0d,%0d required 3,5,3,3",
                         hs[0] - acc, hs[1] - hs[0], hs[2] - hs[1], hs[3] - hs[2]);
            end
        end
    endtask

    task automatic test_errors();
        int acc;
        int we0;
        bit ok;
        rsp_t o;
        rsp_t e;
        we0 = we_pulses;
        send(1'b1, 32'h0040_0000, 32'h1234_5678, 3'd0, acc);
        expect_rsp(32'h0, 1'b1, 1'b1);
        send(1'b0, 32'h1001_0002, 32'h0, 3'd0, acc);
        expect_rsp(32'h0, 1'b1, 1'b1);
        send(1'b0, 32'h1001_00FC, 32'h0, 3'd1, acc);
        expect_rsp(32'h0, 1'b1, 1'b1);
        send(1'b0, 32'h1001_00FC, 32'h0, 3'd0, acc);
        expect_rsp(shadow[63], 1'b0, 1'b1);
        wait_obs(4, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL errors_timeout got %0d responses required 4", obs_q.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                o = obs_q.pop_front();
                e = exp_q.pop_front();
                checks++;
                if (o.data !== e.data || o.err !== e.err || o.last !== e.last) begin
                    errors++;
                    $display("FAIL err_case%0d got data=%h err=%b last=%b required data=%h err=%b last=%b",
                             i, o.data, o.err, o.last, e.data, e.err, e.last);
                end
                $display("rsp err_case%0d data=%h err=%b last=%b", i, o.data, o.err, o.last);
            end
        end
        checks++;
        if (we_pulses != we0) begin
            errors++;
            $display("FAIL err_no_write got %0d pulses required 0", we_pulses - we0);
        end
    endtask

    task automatic test_reset_mid_burst();
        int acc;
        int we0;
        bit ok;
        rsp_t o;
        rsp_t e;
        logic [3*DW+4:0] outs;
        we0 = we_pulses;
        send(1'b0, RAM_BASE + 32'h10, 32'h0, 3'd3, acc);
        expect_rsp(shadow[4], 1'b0, 1'b0);
        wait_valid(ok);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        outs = {Req_Ready_o, Rsp_Valid_o, Rsp_Err_o, Rsp_Last_o, Write_Enable_o,
                Rsp_Rdata_o, Address_o, Write_Data_o};
        checks++;
        if (outs !== '0) begin
            errors++;
            $display("FAIL abort_outputs got %h required 0", outs);
        end
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (4) @(negedge clk);
        checks++;
        if (Req_Ready_o !== 1'b1 || Rsp_Valid_o !== 1'b0) begin
            errors++;
            $display("FAIL abort_recover got ready=%b valid=%b required ready=1 valid=0", Req_Ready_o, Rsp_Valid_o);
        end
        checks++;
        if (obs_q.size() != 1 || exp_q.size() != 1 || we_pulses != we0) begin
            errors++;
            $display("FAIL abort_stray got responses=%0d pulses=%0d required responses=1 pulses=0",
                     obs_q.size(), we_pulses - we0);
        end else begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            checks++;
            if (o.data !== e.data || o.err !== e.err || o.last !== e.last) begin
                errors++;
                $display("FAIL abort_word0 got data=%h last=%b required data=%h last=%b", o.data, o.last, e.data, e.last);
            end
            $display("rsp aborted burst word0 data=%h last=%b", o.data, o.last);
        end
        obs_q.delete();
        exp_q.delete();

        send(1'b0, 32'h0040_0008, 32'h0, 3'd0, acc);
        expect_rsp(rom_word(2), 1'b0, 1'b1);
        wait_obs(1, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL post_reset_timeout got %0d responses required 1", obs_q.size());
        end else begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            if (o.data !== e.data || o.err !== e.err || o.last !== e.last || o.hs - acc != 3) begin
                errors++;
                $display("FAIL post_reset_read got data=%h err=%b last=%b lat=%0d required data=%h err=0 last=1 lat=3",
                         o.data, o.err, o.last, o.hs - acc, e.data);
            end
            $display("rsp post_reset data=%h err=%b last=%b", o.data, o.err, o.last);
        end
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) shadow[i] = ram_init(i);
        test_reset();
        test_rom_read();
        test_write_read();
        test_burst_stall();
        test_errors();
        test_reset_mid_burst();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

endmodule
